// File: rtl/uart_pkg.sv
// uart_pkg
//   Constants shared by the UART transmitter, receiver and the transmit
//   arbiter: the byte width, the default completion watchdog length and the
//   arbiter FSM state encoding.
//   No ports (package).
package uart_pkg;

  localparam int BYTE_W          = 8;
  localparam int DEFAULT_TIMEOUT = 200000;

  typedef logic [BYTE_W-1:0] byte_t;

  // Arbiter FSM encoding, kept as plain constants so older blocks that
  // compare against raw 2-bit values keep working.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester handshake and the transmitter handshake of the
//   shared-UART arbiter.
//   Signals:
//     req_valid   [N]        requester i has a byte pending
//     req_data    [8*N]      byte of requester i at [8*i+7:8*i]
//     req_ready   [N]        one-cycle accept pulse per requester
//     tx_start               one-cycle start pulse to the transmitter
//     tx_data     [8]        byte to the transmitter
//     tx_done                one-cycle completion pulse from the transmitter
//     busy                   transaction in progress
//     grant_id    [IDW]      current/last granted requester
//     err_timeout            one-cycle watchdog expiry pulse
//   Modports:
//     master  clients + transmitter side (drives requests and tx_done)
//     slave   the arbiter itself
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
);

  logic [N-1:0]        req_valid;
  logic [BYTE_W*N-1:0] req_data;
  logic [N-1:0]        req_ready;
  logic                tx_start;
  byte_t               tx_data;
  logic                tx_done;
  logic                busy;
  logic [IDW-1:0]      grant_id;
  logic                err_timeout;

  modport master (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_start, tx_data, busy, grant_id, err_timeout
  );

  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_start, tx_data, busy, grant_id, err_timeout
  );

endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick
//   Combinational round-robin selector. Finds the first set request bit
//   searching from ptr upward, wrapping modulo N.
//   Ports:
//     req  in  [N]    request vector
//     ptr  in  [IDW]  highest-priority index (always < N)
//     any  out        at least one request set
//     g    out [IDW]  selected index
module uart_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] g
);

  logic [N-1:0]   rot;
  logic [IDW-1:0] idx;
  logic [IDW:0]   sum;

  // Rotate so that bit ptr lands at position 0, take the lowest set bit,
  // then add ptr back modulo N. The doubled vector makes the rotate work
  // for any N, not just powers of two.
  always_comb begin
    rot = N'({req, req} >> ptr);
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) idx = IDW'(i);
    end
    sum = {1'b0, idx} + {1'b0, ptr};
    if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
    g   = sum[IDW-1:0];
    any = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between N byte requesters with round-robin
//   arbitration. The granted byte is held on tx_data from tx_start until
//   the transaction ends; a watchdog aborts transactions whose tx_done
//   never arrives.
//   Ports:
//     clk    in   system clock, rising edge
//     reset  in   asynchronous active-high reset
//     bus    slave modport of uart_tx_arbiter_if (requests, transmitter
//            handshake, busy, grant_id, err_timeout)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TO_W    = 18,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [TO_W-1:0] wd;

  logic [N-1:0]   req_ready_q;
  logic           tx_start_q;
  byte_t          tx_data_q;
  logic           busy_q;
  logic [IDW-1:0] grant_q;
  logic           err_q;

  logic           pick_any;
  logic [IDW-1:0] pick_g;
  byte_t          sel_data;
  logic [IDW-1:0] nxt_ptr;

  uart_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (ptr),
    .any (pick_any),
    .g   (pick_g)
  );

  // Byte lane of the requester the picker selected.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_g == IDW'(i)) sel_data = bus.req_data[BYTE_W*i +: BYTE_W];
    end
  end

  // Priority moves to the requester after the one just served.
  assign nxt_ptr = (grant_q == IDW'(N - 1)) ? '0 : grant_q + IDW'(1);

  // Main FSM. req_ready, tx_start and err_timeout default low every cycle
  // so they can only ever be one-cycle pulses. tx_done is checked before
  // the watchdog so a completion arriving on the expiry cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      wd          <= '0;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      err_q       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            tx_data_q   <= sel_data;
            grant_q     <= pick_g;
            req_ready_q <= N'(1) << pick_g;
            tx_start_q  <= 1'b1;
            busy_q      <= 1'b1;
            state       <= ST_START;
          end
        end
        ST_START: begin
          wd    <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.tx_done) begin
            busy_q <= 1'b0;
            ptr    <= nxt_ptr;
            state  <= ST_IDLE;
          end else if (wd == TO_W'(TIMEOUT - 1)) begin
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            ptr    <= nxt_ptr;
            state  <= ST_IDLE;
          end else begin
            wd <= wd + TO_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_q;
  assign bus.err_timeout = err_q;

endmodule
